// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-input mux round-robin arbiter.
// Optional lock feature: define ARB_LOCK_EN.
package mux_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int SEL_W  = 2;
    localparam int HOLD_W = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

    // One-hot (or zero) vector to index; zero maps to 0.
    function automatic logic [SEL_W-1:0] onehot_to_idx(
        input logic [N_REQ-1:0] oh
    );
        logic [SEL_W-1:0] idx;
        idx = '0;
        unique case (1'b1)
            oh[0]:   idx = 2'd0;
            oh[1]:   idx = 2'd1;
            oh[2]:   idx = 2'd2;
            oh[3]:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [N_REQ-1:0] idx_to_onehot(
        input logic [SEL_W-1:0] idx
    );
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_4x1_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from last+1 with wrap,
// skipping any requester set in the exclude mask.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    input  logic [N_REQ-1:0] excl,
    output logic [SEL_W-1:0] winner,
    output logic             found
);

    // First eligible requester after last, wrapping 3 -> 0.
    always_comb begin
        logic [SEL_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = last + SEL_W'(i);
            if (!found && req[idx] && !excl[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter driving mux_4x1 selects with a bounded hold time.
// Optional: ARB_LOCK_EN adds a lock input that suppresses hold expiry.
module mux_4x1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int NUM_REQ  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic             s0,
    output logic             s1,
    output logic             busy
);

    if (NUM_REQ != 4) begin : g_bad_num_req
        $error("NUM_REQ must be 4 to match mux_4x1");
    end

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..15");
    end

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q,   gnt_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [SEL_W-1:0]  last_q,  last_d;

    logic [SEL_W-1:0]  owner;
    logic              own_req;
    logic              lock_act;
    logic [N_REQ-1:0]  pick_excl;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_found;

`ifdef ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    assign owner     = onehot_to_idx(gnt_q);
    assign own_req   = req[owner];
    // The current owner never wins its own release or expiry search.
    assign pick_excl = (state_q == GRANT) ? gnt_q : '0;

    rr_pick u_pick (
        .req    (req),
        .last   (last_q),
        .excl   (pick_excl),
        .winner (pick_idx),
        .found  (pick_found)
    );

    // Next-state logic: grant, release, expiry and lock handling.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = idx_to_onehot(pick_idx);
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    hold_d = '0;
                    if (pick_found) begin
                        gnt_d  = idx_to_onehot(pick_idx);
                        sel_d  = pick_idx;
                        last_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (lock_act) begin
                    if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (pick_found) begin
                        gnt_d  = idx_to_onehot(pick_idx);
                        sel_d  = pick_idx;
                        last_d = pick_idx;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State register; reset leaves last=3 so requester 0 leads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            hold_q  <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign gnt  = gnt_q;
    assign s0   = sel_q[0];
    assign s1   = sel_q[1];
    assign busy = |gnt_q;

endmodule
